// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// FSM state encoding and select-width helper.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // A 1-to-1 or 1-to-2 demux still needs a 1-bit select.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream in, N broadcast-data channels out.
// The slave modport is the demux's view; master is the source/consumer side.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8
);
    localparam int SEL_W = clog2_min1(N_OUT);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic [SEL_W-1:0]  in_sel;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;

    modport slave (
        input  in_data, in_valid, in_last, in_sel, out_ready,
        output in_ready, out_data, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, in_sel, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );

endinterface

// File: rtl/stream_demux_obuf.sv
// One-entry output register holding {data, last, ch}.
// A push wins over a pop in the same cycle so the slot reloads without a bubble.
module stream_demux_obuf #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic [SEL_W-1:0]  i_ch,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [SEL_W-1:0]  o_ch
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [SEL_W-1:0]  r_ch;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_ch    <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
            r_ch    <= i_ch;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_ch    = r_ch;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer with one registered output stage.
// Optional saturating drop counter enabled by macro STREAM_DEMUX_DROP_CNT_EN.
//
// state   | meaning
// IDLE    | no packet open; next accepted beat is a first beat and samples in_sel
// FWD     | packet open; beats go to the channel latched on the first beat
// DROP    | packet open with out-of-range select; beats consumed and discarded
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int CNT_W  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    stream_demux_if.slave bus,
    output logic          o_busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] o_drop_cnt
`endif
);

    localparam int SEL_W = clog2_min1(N_OUT);
    localparam logic [SEL_W:0]   LP_N_OUT = (SEL_W+1)'(N_OUT);
    localparam logic [N_OUT-1:0] LP_ONE   = {{(N_OUT-1){1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_nxt;
    logic [SEL_W-1:0]  r_ch;
    logic [SEL_W-1:0]  w_ch_nxt;
    logic              w_push;
    logic              w_drop_beat;
    logic              w_accept;
    logic              w_pop;
    logic              w_sel_ok;
    logic              w_buf_valid;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_buf_last;
    logic [SEL_W-1:0]  w_buf_ch;
    logic [N_OUT-1:0]  w_out_valid;

    assign w_sel_ok    = ({1'b0, bus.in_sel} < LP_N_OUT);
    assign w_out_valid = w_buf_valid ? (LP_ONE << w_buf_ch) : '0;
    // Only the addressed channel's ready can pop the buffer.
    assign w_pop       = |(w_out_valid & bus.out_ready);
    assign bus.in_ready = (r_state == ST_DROP) | ~w_buf_valid | w_pop;
    assign w_accept    = bus.in_valid & bus.in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_push      = 1'b0;
        w_drop_beat = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_ok) begin
                        w_push      = 1'b1;
                        w_ch_nxt    = bus.in_sel;
                        w_state_nxt = bus.in_last ? ST_IDLE : ST_FWD;
                    end else begin
                        w_drop_beat = 1'b1;
                        w_state_nxt = bus.in_last ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (w_accept) begin
                    w_push = 1'b1;
                    if (bus.in_last) w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_accept) begin
                    w_drop_beat = 1'b1;
                    if (bus.in_last) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    stream_demux_obuf #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_obuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.in_data),
        .i_last  (bus.in_last),
        .i_ch    (w_ch_nxt),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_last  (w_buf_last),
        .o_ch    (w_buf_ch)
    );

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_buf_data;
    assign bus.out_last  = w_buf_last;
    assign o_busy        = (r_state != ST_IDLE);

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_beat && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: an 8-channel instance and a 6-channel instance
// (the latter exercises out-of-range selects and, when enabled, the drop counter).
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(8), .N_OUT(8)) a ();
    stream_demux_if #(.DATA_W(8), .N_OUT(6)) b ();

    logic busy_a, busy_b;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] drop_a;
    logic [2:0]  drop_b;
`endif

    stream_demux #(.DATA_W(8), .N_OUT(8), .CNT_W(16)) u_dut8 (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (a),
        .o_busy (busy_a)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .o_drop_cnt (drop_a)
`endif
    );

    stream_demux #(.DATA_W(8), .N_OUT(6), .CNT_W(3)) u_dut6 (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (b),
        .o_busy (busy_b)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .o_drop_cnt (drop_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 8-channel DUT, check in_ready before the edge and outputs after it.
    task automatic cyc8(input string tag, input logic v, input logic [7:0] d, input logic l,
                        input logic [2:0] s, input logic [7:0] rdy, input logic exp_rdy,
                        input logic [7:0] exp_ov, input logic [7:0] exp_d, input logic exp_l,
                        input logic exp_busy);
        a.in_valid = v; a.in_data = d; a.in_last = l; a.in_sel = s; a.out_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, 64'(a.in_ready), 64'(exp_rdy));
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 64'(a.out_valid), 64'(exp_ov));
        chk({tag, ".busy"}, 64'(busy_a), 64'(exp_busy));
        if (exp_ov != 8'h00) begin
            chk({tag, ".out_data"}, 64'(a.out_data), 64'(exp_d));
            chk({tag, ".out_last"}, 64'(a.out_last), 64'(exp_l));
        end
    endtask

    task automatic cyc6(input string tag, input logic v, input logic [7:0] d, input logic l,
                        input logic [2:0] s, input logic [5:0] rdy, input logic exp_rdy,
                        input logic [5:0] exp_ov, input logic [7:0] exp_d, input logic exp_l,
                        input logic exp_busy);
        b.in_valid = v; b.in_data = d; b.in_last = l; b.in_sel = s; b.out_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, 64'(b.in_ready), 64'(exp_rdy));
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, 64'(b.out_valid), 64'(exp_ov));
        chk({tag, ".busy"}, 64'(busy_b), 64'(exp_busy));
        if (exp_ov != 6'h00) begin
            chk({tag, ".out_data"}, 64'(b.out_data), 64'(exp_d));
            chk({tag, ".out_last"}, 64'(b.out_last), 64'(exp_l));
        end
    endtask

    initial begin
        a.in_valid = 0; a.in_data = 0; a.in_last = 0; a.in_sel = 0; a.out_ready = '1;
        b.in_valid = 0; b.in_data = 0; b.in_last = 0; b.in_sel = 0; b.out_ready = '1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(a.out_valid), 64'h0);
        chk("rst.out_data", 64'(a.out_data), 64'h0);
        chk("rst.out_last", 64'(a.out_last), 64'h0);
        chk("rst.busy", 64'(busy_a), 64'h0);
        chk("rst.in_ready", 64'(a.in_ready), 64'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("rst.drop_cnt", 64'(drop_a), 64'h0);
`endif
        rst = 0;

        // 1: two 3-beat packets, all ready
        cyc8("t1.b1", 1, 8'h11, 0, 3'd5, 8'hFF, 1, 8'h20, 8'h11, 0, 1);
        cyc8("t1.b2", 1, 8'h12, 0, 3'd5, 8'hFF, 1, 8'h20, 8'h12, 0, 1);
        cyc8("t1.b3", 1, 8'h13, 1, 3'd5, 8'hFF, 1, 8'h20, 8'h13, 1, 0);
        cyc8("t1.b4", 1, 8'h21, 0, 3'd2, 8'hFF, 1, 8'h04, 8'h21, 0, 1);
        cyc8("t1.b5", 1, 8'h22, 0, 3'd2, 8'hFF, 1, 8'h04, 8'h22, 0, 1);
        cyc8("t1.b6", 1, 8'h23, 1, 3'd2, 8'hFF, 1, 8'h04, 8'h23, 1, 0);
        cyc8("t1.idle", 0, 8'h00, 0, 3'd0, 8'hFF, 1, 8'h00, 8'h00, 0, 0);

        // 2: select changes mid-packet are ignored
        cyc8("t2.b1", 1, 8'h31, 0, 3'd3, 8'hFF, 1, 8'h08, 8'h31, 0, 1);
        cyc8("t2.b2", 1, 8'h32, 0, 3'd6, 8'hFF, 1, 8'h08, 8'h32, 0, 1);
        cyc8("t2.b3", 1, 8'h33, 1, 3'd6, 8'hFF, 1, 8'h08, 8'h33, 1, 0);
        cyc8("t2.idle", 0, 8'h00, 0, 3'd0, 8'hFF, 1, 8'h00, 8'h00, 0, 0);

        // 3: ch4 stalled for 5 cycles; other readies toggle without effect
        cyc8("t3.a", 1, 8'h41, 0, 3'd4, 8'hEF, 1, 8'h10, 8'h41, 0, 1);
        cyc8("t3.s1", 1, 8'h42, 0, 3'd4, 8'hEF, 0, 8'h10, 8'h41, 0, 1);
        cyc8("t3.s2", 1, 8'h42, 0, 3'd4, 8'h00, 0, 8'h10, 8'h41, 0, 1);
        cyc8("t3.s3", 1, 8'h42, 0, 3'd4, 8'hEF, 0, 8'h10, 8'h41, 0, 1);
        cyc8("t3.s4", 1, 8'h42, 0, 3'd4, 8'h6F, 0, 8'h10, 8'h41, 0, 1);
        cyc8("t3.s5", 1, 8'h42, 0, 3'd4, 8'hEF, 0, 8'h10, 8'h41, 0, 1);
        cyc8("t3.go", 1, 8'h42, 0, 3'd4, 8'h10, 1, 8'h10, 8'h42, 0, 1);
        cyc8("t3.end", 1, 8'h43, 1, 3'd4, 8'h10, 1, 8'h10, 8'h43, 1, 0);
        cyc8("t3.idle", 0, 8'h00, 0, 3'd0, 8'h10, 1, 8'h00, 8'h00, 0, 0);

        // 4: 6-channel instance, out-of-range selects are dropped
        cyc6("t4.hold", 1, 8'h91, 1, 3'd2, 6'h00, 1, 6'h04, 8'h91, 1, 0);
        cyc6("t4.blk", 1, 8'h71, 0, 3'd7, 6'h3B, 0, 6'h04, 8'h91, 1, 0);
        cyc6("t4.d1", 1, 8'h71, 0, 3'd7, 6'h3F, 1, 6'h00, 8'h00, 0, 1);
        cyc6("t4.d2", 1, 8'h72, 0, 3'd1, 6'h00, 1, 6'h00, 8'h00, 0, 1);
        cyc6("t4.d3", 1, 8'h73, 0, 3'd1, 6'h00, 1, 6'h00, 8'h00, 0, 1);
        cyc6("t4.d4", 1, 8'h74, 1, 3'd7, 6'h00, 1, 6'h00, 8'h00, 0, 0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("t4.drop4", 64'(drop_b), 64'd4);
`endif
        cyc6("t4.f1", 1, 8'h81, 0, 3'd1, 6'h3F, 1, 6'h02, 8'h81, 0, 1);
        cyc6("t4.f2", 1, 8'h82, 1, 3'd7, 6'h3F, 1, 6'h02, 8'h82, 1, 0);
        cyc6("t4.sel6", 1, 8'h83, 1, 3'd6, 6'h3F, 1, 6'h00, 8'h00, 0, 0);
        cyc6("t4.sel5", 1, 8'h84, 1, 3'd5, 6'h3F, 1, 6'h20, 8'h84, 1, 0);
        cyc6("t4.sel7a", 1, 8'h85, 1, 3'd7, 6'h3F, 1, 6'h00, 8'h00, 0, 0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("t4.drop6", 64'(drop_b), 64'd6);
`endif
        cyc6("t4.sel6b", 1, 8'h86, 1, 3'd6, 6'h3F, 1, 6'h00, 8'h00, 0, 0);
        cyc6("t4.sel7b", 1, 8'h87, 1, 3'd7, 6'h3F, 1, 6'h00, 8'h00, 0, 0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("t4.drop_sat", 64'(drop_b), 64'd7);
`endif
        cyc6("t4.idle", 0, 8'h00, 0, 3'd0, 6'h3F, 1, 6'h00, 8'h00, 0, 0);

        // 5: reset mid-packet with a beat buffered
        cyc8("t5.b1", 1, 8'h51, 0, 3'd1, 8'h00, 1, 8'h02, 8'h51, 0, 1);
        a.in_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        chk("t5.out_valid", 64'(a.out_valid), 64'h0);
        chk("t5.busy", 64'(busy_a), 64'h0);
        chk("t5.out_data", 64'(a.out_data), 64'h0);
        chk("t5.in_ready", 64'(a.in_ready), 64'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("t5.drop_clr", 64'(drop_b), 64'h0);
`endif
        rst = 0;
        cyc8("t5.resel", 1, 8'h52, 1, 3'd6, 8'hFF, 1, 8'h40, 8'h52, 1, 0);

        // 6: back-to-back single-beat packets cycling all channels
        for (int i = 0; i < 8; i++) begin
            cyc8($sformatf("t6.s%0d", i), 1, 8'h60 + 8'(i), 1, 3'(i), 8'hFF, 1,
                 8'h01 << i, 8'h60 + 8'(i), 1, 0);
        end
        cyc8("t6.idle", 0, 8'h00, 0, 3'd0, 8'hFF, 1, 8'h00, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
